// File: rtl/uf_pkg.sv
// Shared opcodes, idle-bus sentinels, latency defaults and FSM encoding for the
// uf_alu_mul functional unit.
package uf_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;

   localparam logic [15:0] UF_SEM_VALOR_DEF = 16'hFFF0;
   localparam logic [2:0]  UF_TAG_NULO_DEF  = 3'b000;

   localparam int UF_LAT_ALU_DEF = 1;
   localparam int UF_LAT_MUL_DEF = 3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_EXEC     = 2'd1,
      ST_WAIT_CDB = 2'd2,
      ST_DONE     = 2'd3
   } uf_state_t;

endpackage

// File: rtl/uf_alu_core.sv
// Combinational result datapath of the functional unit (A, B, Op) -> result.
// Signed less-than on Op 101 exists only when UF_SLT_EN is defined.
module uf_alu_core
   import uf_pkg::*;
(
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   input  logic [2:0]  i_op,
   output logic [15:0] o_result
);

   always_comb begin
      o_result = 16'h0000;
      case (i_op)
         OP_ADD:  o_result = i_a + i_b;
         OP_SUB:  o_result = i_a - i_b;
         OP_MUL:  o_result = i_a * i_b;
         OP_AND:  o_result = i_a & i_b;
         OP_OR:   o_result = i_a | i_b;
`ifdef UF_SLT_EN
         OP_SLT:  o_result = ($signed(i_a) < $signed(i_b)) ? 16'h0001 : 16'h0000;
`endif
         default: o_result = 16'h0000;
      endcase
   end

endmodule

// File: rtl/uf_alu_mul.sv
// Tomasulo ALU/multiplier functional unit: edge-triggered accept, latency count,
// CDB request/broadcast and one-cycle Done. Optional SLT via macro UF_SLT_EN.
module uf_alu_mul
   import uf_pkg::*;
#(
   parameter int          LAT_ALU   = UF_LAT_ALU_DEF,
   parameter int          LAT_MUL   = UF_LAT_MUL_DEF,
   parameter logic [15:0] SEM_VALOR = UF_SEM_VALOR_DEF,
   parameter logic [2:0]  TAG_NULO  = UF_TAG_NULO_DEF
)
(
   input  logic        Clock,
   input  logic        Resetn,
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        Ready_to_uf,
   input  logic [2:0]  Op,
   input  logic [2:0]  Tag,
   input  logic        Cdb_grant,
   output logic        Cdb_req,
   output logic [2:0]  Qi_CDB,
   output logic [15:0] Qi_CDB_data,
   output logic        Busy_uf,
   output logic        Done
);

   localparam int LAT_MAX = (LAT_ALU > LAT_MUL) ? LAT_ALU : LAT_MUL;
   localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

   uf_state_t          r_state;
   logic [CNT_W-1:0]   r_count;
   logic               r_ready_q;
   logic               r_armed;
   logic               r_cdb_req;
   logic [2:0]         r_qi_cdb;
   logic [15:0]        r_qi_data;
   logic               r_busy;
   logic               r_done;

   logic [15:0]        r_a;
   logic [15:0]        r_b;
   logic [2:0]         r_op;
   logic [2:0]         r_tag;

   logic               w_accept;
   logic [CNT_W-1:0]   w_lat_load;
   logic [15:0]        w_result;

   // A level that is already high when reset releases is not a fresh request:
   // the unit arms only after it has seen Ready_to_uf low once.
   assign w_accept   = (r_state == ST_IDLE) && Ready_to_uf && !r_ready_q && r_armed;
   assign w_lat_load = (Op == OP_MUL) ? CNT_W'(LAT_MUL - 1) : CNT_W'(LAT_ALU - 1);

   uf_alu_core u_core (
      .i_a      (r_a),
      .i_b      (r_b),
      .i_op     (r_op),
      .o_result (w_result)
   );

   always_ff @(posedge Clock) begin
      if (w_accept) begin
         r_a   <= A;
         r_b   <= B;
         r_op  <= Op;
         r_tag <= Tag;
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_state   <= ST_IDLE;
         r_count   <= '0;
         r_ready_q <= 1'b0;
         r_armed   <= 1'b0;
         r_cdb_req <= 1'b0;
         r_qi_cdb  <= TAG_NULO;
         r_qi_data <= SEM_VALOR;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_ready_q <= Ready_to_uf;
         if (!Ready_to_uf)
            r_armed <= 1'b1;
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state <= ST_EXEC;
                  r_count <= w_lat_load;
                  r_busy  <= 1'b1;
               end
            end
            ST_EXEC: begin
               if (r_count != '0) begin
                  r_count <= r_count - 1'b1;
               end else begin
                  r_state   <= ST_WAIT_CDB;
                  r_cdb_req <= 1'b1;
                  r_qi_cdb  <= r_tag;
                  r_qi_data <= w_result;
               end
            end
            ST_WAIT_CDB: begin
               if (Cdb_grant) begin
                  r_state   <= ST_DONE;
                  r_cdb_req <= 1'b0;
                  r_qi_cdb  <= TAG_NULO;
                  r_qi_data <= SEM_VALOR;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign Cdb_req     = r_cdb_req;
   assign Qi_CDB      = r_qi_cdb;
   assign Qi_CDB_data = r_qi_data;
   assign Busy_uf     = r_busy;
   assign Done        = r_done;

endmodule

// File: tb/tb_uf_alu_mul.sv
// Self-checking bench for uf_alu_mul against a plain-arithmetic reference model.
module tb_uf_alu_mul;

   localparam int LAT_ALU_TB = 1;
   localparam int LAT_MUL_TB = 3;

   logic        Clock;
   logic        Resetn;
   logic [15:0] A;
   logic [15:0] B;
   logic        Ready_to_uf;
   logic [2:0]  Op;
   logic [2:0]  Tag;
   logic        Cdb_grant;
   logic        Cdb_req;
   logic [2:0]  Qi_CDB;
   logic [15:0] Qi_CDB_data;
   logic        Busy_uf;
   logic        Done;

   int checks;
   int failures;

   uf_alu_mul dut (
      .Clock       (Clock),
      .Resetn      (Resetn),
      .A           (A),
      .B           (B),
      .Ready_to_uf (Ready_to_uf),
      .Op          (Op),
      .Tag         (Tag),
      .Cdb_grant   (Cdb_grant),
      .Cdb_req     (Cdb_req),
      .Qi_CDB      (Qi_CDB),
      .Qi_CDB_data (Qi_CDB_data),
      .Busy_uf     (Busy_uf),
      .Done        (Done)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic logic [15:0] ref_result(input logic [15:0] a, input logic [15:0] b,
                                              input logic [2:0] op);
      longint ua;
      longint ub;
      ua = longint'(a);
      ub = longint'(b);
      case (op)
         3'd0: return 16'((ua + ub) % 65536);
         3'd1: return 16'((ua + 65536 - ub) % 65536);
         3'd2: return 16'((ua * ub) % 65536);
         3'd3: return a & b;
         3'd4: return a | b;
`ifdef UF_SLT_EN
         3'd5: return (int'($signed(a)) < int'($signed(b))) ? 16'd1 : 16'd0;
`endif
         default: return 16'd0;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] op);
      return (op == 3'd2) ? LAT_MUL_TB : LAT_ALU_TB;
   endfunction

   // One full transaction: accept, execute, wait gdelay grant-less cycles, broadcast, Done.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                         input logic [2:0] tag, input int gdelay, input bit early,
                         input string nm);
      logic [15:0] exp;
      int lat;
      exp = ref_result(a, b, op);
      lat = ref_lat(op);
      Ready_to_uf = 1'b0;
      @(posedge Clock); #1;
      A = a; B = b; Op = op; Tag = tag; Cdb_grant = early; Ready_to_uf = 1'b1;
      @(posedge Clock); #1;
      Ready_to_uf = 1'b0;
      A = 16'($urandom); B = 16'($urandom); Op = 3'($urandom); Tag = 3'($urandom_range(1, 7));
      checks++;
      if (Busy_uf !== 1'b1 || Cdb_req !== 1'b0) begin
         failures++;
         $display("FAIL %s accept busy=%b req=%b required busy=1 req=0", nm, Busy_uf, Cdb_req);
      end
      for (int k = 1; k < lat; k++) begin
         @(posedge Clock); #1;
         checks++;
         if (Busy_uf !== 1'b1 || Cdb_req !== 1'b0) begin
            failures++;
            $display("FAIL %s exec%0d busy=%b req=%b required busy=1 req=0", nm, k, Busy_uf, Cdb_req);
         end
      end
      @(posedge Clock); #1;
      checks++;
      if (Cdb_req !== 1'b1 || Qi_CDB !== tag || Qi_CDB_data !== exp || Busy_uf !== 1'b1 || Done !== 1'b0) begin
         failures++;
         $display("FAIL %s bcast req=%b tag=%0d data=%h busy=%b done=%b required req=1 tag=%0d data=%h busy=1 done=0",
                  nm, Cdb_req, Qi_CDB, Qi_CDB_data, Busy_uf, Done, tag, exp);
      end
      if (!early) begin
         for (int k = 0; k < gdelay; k++) begin
            @(posedge Clock); #1;
            checks++;
            if (Cdb_req !== 1'b1 || Qi_CDB_data !== exp || Done !== 1'b0) begin
               failures++;
               $display("FAIL %s hold%0d req=%b data=%h done=%b required req=1 data=%h done=0",
                        nm, k, Cdb_req, Qi_CDB_data, Done, exp);
            end
         end
         Cdb_grant = 1'b1;
      end
      @(posedge Clock); #1;
      Cdb_grant = 1'b0;
      checks++;
      if (Done !== 1'b1 || Cdb_req !== 1'b0 || Qi_CDB !== 3'd0 || Qi_CDB_data !== 16'hFFF0 || Busy_uf !== 1'b0) begin
         failures++;
         $display("FAIL %s done done=%b req=%b tag=%0d data=%h busy=%b required done=1 req=0 tag=0 data=fff0 busy=0",
                  nm, Done, Cdb_req, Qi_CDB, Qi_CDB_data, Busy_uf);
      end
      @(posedge Clock); #1;
      checks++;
      if (Done !== 1'b0 || Busy_uf !== 1'b0 || Cdb_req !== 1'b0) begin
         failures++;
         $display("FAIL %s after done=%b busy=%b req=%b required 0 0 0", nm, Done, Busy_uf, Cdb_req);
      end
   endtask

   task automatic test_reset;
      Resetn = 1'b0; Ready_to_uf = 1'b1; Cdb_grant = 1'b1;
      A = 16'h0005; B = 16'h0007; Op = 3'd0; Tag = 3'd3;
      #2;
      for (int k = 0; k < 3; k++) begin
         @(posedge Clock); #1;
         checks++;
         if (Cdb_req !== 1'b0 || Qi_CDB !== 3'd0 || Qi_CDB_data !== 16'hFFF0 || Busy_uf !== 1'b0 || Done !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold req=%b tag=%0d data=%h busy=%b done=%b required 0 0 fff0 0 0",
                     Cdb_req, Qi_CDB, Qi_CDB_data, Busy_uf, Done);
         end
      end
      Resetn = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge Clock); #1;
         checks++;
         if (Busy_uf !== 1'b0 || Cdb_req !== 1'b0 || Done !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_level busy=%b req=%b done=%b required 0 0 0", Busy_uf, Cdb_req, Done);
         end
      end
      Ready_to_uf = 1'b0;
      @(posedge Clock); #1;
      Ready_to_uf = 1'b1;
      @(posedge Clock); #1;
      checks++;
      if (Busy_uf !== 1'b1) begin
         failures++;
         $display("FAIL reset_new_edge busy=%b required 1", Busy_uf);
      end
      repeat (2) @(posedge Clock);
      #1;
      checks++;
      if (Done !== 1'b1 || Busy_uf !== 1'b0) begin
         failures++;
         $display("FAIL reset_first_done done=%b busy=%b required done=1 busy=0", Done, Busy_uf);
      end
      Cdb_grant = 1'b0;
      Ready_to_uf = 1'b0;
      @(posedge Clock); #1;
   endtask

   task automatic test_add_immediate;
      run_op(16'h0005, 16'h0007, 3'd0, 3'd3, 0, 1'b1, "add_imm");
   endtask

   task automatic test_mul_delayed;
      run_op(16'h0100, 16'h0101, 3'd2, 3'd5, 4, 1'b0, "mul_delay");
   endtask

   task automatic test_sub_wrap;
      run_op(16'h0000, 16'h0001, 3'd1, 3'd2, 1, 1'b0, "sub_wrap");
      run_op(16'hFFFF, 16'h0003, 3'd0, 3'd7, 0, 1'b0, "add_wrap");
      run_op(16'hF0F0, 16'h0FF0, 3'd3, 3'd1, 0, 1'b1, "and");
      run_op(16'hF000, 16'h000F, 3'd4, 3'd4, 2, 1'b0, "or");
      run_op(16'h1234, 16'h5678, 3'd6, 3'd6, 0, 1'b1, "unknown6");
      run_op(16'h1234, 16'h5678, 3'd7, 3'd6, 0, 1'b0, "unknown7");
      run_op(16'hFFF0, 16'h0000, 3'd0, 3'd2, 0, 1'b1, "sentinel_result");
   endtask

   task automatic test_slt;
      run_op(16'hFFFF, 16'h0001, 3'd5, 3'd1, 0, 1'b1, "slt_neg");
      run_op(16'h0001, 16'hFFFF, 3'd5, 3'd2, 1, 1'b0, "slt_pos");
   endtask

   task automatic test_level_hold;
      int bcasts;
      int dones;
      logic prev_req;
      logic [15:0] seen;
      Ready_to_uf = 1'b0; Cdb_grant = 1'b1;
      @(posedge Clock); #1;
      A = 16'h0011; B = 16'h0022; Op = 3'd0; Tag = 3'd6; Ready_to_uf = 1'b1;
      bcasts = 0; dones = 0; prev_req = 1'b0; seen = 16'h0;
      for (int k = 0; k < 12; k++) begin
         @(posedge Clock); #1;
         if (Cdb_req && !prev_req) begin bcasts++; seen = Qi_CDB_data; end
         if (Done) dones++;
         prev_req = Cdb_req;
      end
      checks++;
      if (bcasts != 1 || dones != 1 || seen !== 16'h0033) begin
         failures++;
         $display("FAIL level_hold bcasts=%0d dones=%0d data=%h required 1 1 0033", bcasts, dones, seen);
      end
      Ready_to_uf = 1'b0;
      @(posedge Clock); #1;
      A = 16'h0003; B = 16'h0004; Op = 3'd2; Tag = 3'd5; Ready_to_uf = 1'b1;
      @(posedge Clock); #1;
      Ready_to_uf = 1'b0; A = 16'h0009; Op = 3'd0;
      @(posedge Clock); #1;
      Ready_to_uf = 1'b1;
      bcasts = 0; dones = 0; prev_req = 1'b0; seen = 16'h0;
      for (int k = 0; k < 15; k++) begin
         @(posedge Clock); #1;
         if (Cdb_req && !prev_req) begin bcasts++; seen = Qi_CDB_data; end
         if (Done) dones++;
         prev_req = Cdb_req;
      end
      checks++;
      if (bcasts != 1 || dones != 1 || seen !== 16'h000C) begin
         failures++;
         $display("FAIL edge_in_exec bcasts=%0d dones=%0d data=%h required 1 1 000c", bcasts, dones, seen);
      end
      Ready_to_uf = 1'b0; Cdb_grant = 1'b0;
      @(posedge Clock); #1;
   endtask

   task automatic test_reset_mid;
      Cdb_grant = 1'b0; Ready_to_uf = 1'b0;
      @(posedge Clock); #1;
      A = 16'h0100; B = 16'h0002; Op = 3'd2; Tag = 3'd4; Ready_to_uf = 1'b1;
      @(posedge Clock); #1;
      Ready_to_uf = 1'b0;
      repeat (3) @(posedge Clock);
      #1;
      checks++;
      if (Cdb_req !== 1'b1 || Qi_CDB_data !== 16'h0200) begin
         failures++;
         $display("FAIL rst_mid_wait req=%b data=%h required req=1 data=0200", Cdb_req, Qi_CDB_data);
      end
      #3;
      Resetn = 1'b0;
      #1;
      checks++;
      if (Cdb_req !== 1'b0 || Qi_CDB !== 3'd0 || Qi_CDB_data !== 16'hFFF0 || Busy_uf !== 1'b0 || Done !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_async req=%b tag=%0d data=%h busy=%b done=%b required 0 0 fff0 0 0",
                  Cdb_req, Qi_CDB, Qi_CDB_data, Busy_uf, Done);
      end
      #1;
      Resetn = 1'b1;
      Cdb_grant = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge Clock); #1;
         checks++;
         if (Done !== 1'b0 || Cdb_req !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_after%0d done=%b req=%b required 0 0", k, Done, Cdb_req);
         end
      end
      Cdb_grant = 1'b0;
   endtask

   task automatic test_random;
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  op;
      logic [2:0]  tag;
      for (int n = 0; n < 30; n++) begin
         a   = 16'($urandom);
         b   = 16'($urandom);
         op  = 3'($urandom_range(0, 7));
         tag = 3'($urandom_range(1, 7));
         run_op(a, b, op, tag, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "random");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_add_immediate();
      test_mul_delayed();
      test_sub_wrap();
      test_slt();
      test_level_hold();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
